// File: rtl/code_lock_pkg.sv
// Shared types and defaults for the code lock FSM.
package code_lock_pkg;

  // Width of the tries_left output
  localparam int unsigned TRIES_W = 4;

  // Parameter defaults
  localparam int unsigned DEF_CODE_W      = 3;
  localparam int unsigned DEF_MAX_TRIES   = 3;
  localparam int unsigned DEF_LOCK_CYCLES = 16;
  localparam int unsigned DEF_RESET_CODE  = 1;

  typedef enum logic [1:0] {
    ST_SECURE  = 2'b00,
    ST_OPEN    = 2'b01,
    ST_LOCKOUT = 2'b10
  } state_e;

endpackage

// File: rtl/code_lock_fsm_compare.sv
// Combinational "equal to stored code and nonzero" test.
module code_compare #(
  parameter int unsigned CODE_W = 3
) (
  input  logic [CODE_W-1:0] code_a_i,
  input  logic [CODE_W-1:0] code_b_i,
  output logic              eq_nz_o
);

  // An all-zero entry never matches, even against an all-zero reference
  always_comb begin
    eq_nz_o = (code_a_i == code_b_i) && (|code_a_i);
  end

endmodule

// File: rtl/code_lock_fsm.sv
// Code lock: SECURE / OPEN / LOCKOUT with retry counting and timed lockout.
module code_lock_fsm
  import code_lock_pkg::*;
#(
  parameter int unsigned       CODE_W      = DEF_CODE_W,
  parameter int unsigned       MAX_TRIES   = DEF_MAX_TRIES,
  parameter int unsigned       LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter logic [CODE_W-1:0] RESET_CODE  = CODE_W'(DEF_RESET_CODE)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [CODE_W-1:0]  code_in,
  input  logic               code_valid,
  input  logic               prog,
  input  logic               lock_req,
  output logic               unlocked,
  output logic               lockout,
  output logic               match,
  output logic               fail,
  output logic [TRIES_W-1:0] tries_left
);

  if (CODE_W < 2 || CODE_W > 16) begin : g_bad_code_w
    $error("code_lock_fsm: CODE_W must be in 2..16");
  end
  if (MAX_TRIES < 1 || MAX_TRIES > 15) begin : g_bad_max_tries
    $error("code_lock_fsm: MAX_TRIES must be in 1..15");
  end
  if (LOCK_CYCLES < 1 || LOCK_CYCLES > 65535) begin : g_bad_lock_cycles
    $error("code_lock_fsm: LOCK_CYCLES must be in 1..65535");
  end
  if (RESET_CODE == '0) begin : g_bad_reset_code
    $error("code_lock_fsm: RESET_CODE must be nonzero");
  end

  localparam logic [TRIES_W-1:0] MAX_T  = TRIES_W'(MAX_TRIES);
  localparam logic [15:0]         LOCK_T = 16'(LOCK_CYCLES - 1);

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [TRIES_W-1:0]  fails_q, fails_d;
  logic [15:0]         timer_q, timer_d;
  logic                unlocked_q, unlocked_d;
  logic                lockout_q, lockout_d;
  logic                match_q, match_d;
  logic                fail_q, fail_d;
  logic [TRIES_W-1:0]  tries_q, tries_d;
  logic                code_ok;
  logic [TRIES_W-1:0]  fails_inc;

  code_compare #(
    .CODE_W (CODE_W)
  ) u_cmp (
    .code_a_i (code_in),
    .code_b_i (code_q),
    .eq_nz_o  (code_ok)
  );

  assign fails_inc = fails_q + TRIES_W'(1);

  // Next-state, datapath and registered-output values
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    fails_d = fails_q;
    timer_d = timer_q;
    match_d = 1'b0;
    fail_d  = 1'b0;

    unique case (state_q)
      ST_SECURE: begin
        if (code_valid) begin
          if (code_ok) begin
            state_d = ST_OPEN;
            match_d = 1'b1;
            fails_d = '0;
          end else begin
            fail_d = 1'b1;
            // Counter saturates at MAX_TRIES, which is also the lockout trigger
            if (fails_inc >= MAX_T) begin
              fails_d = MAX_T;
              state_d = ST_LOCKOUT;
              timer_d = LOCK_T;
            end else begin
              fails_d = fails_inc;
            end
          end
        end
      end

      ST_OPEN: begin
        // lock_req takes priority over any concurrent entry
        if (lock_req) begin
          state_d = ST_SECURE;
        end else if (code_valid && prog) begin
          if (|code_in) begin
            code_d  = code_in;
            match_d = 1'b1;
          end else begin
            fail_d = 1'b1;
          end
        end
      end

      ST_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = ST_SECURE;
          fails_d = '0;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end

      default: begin
        state_d = ST_SECURE;
        fails_d = '0;
        timer_d = '0;
      end
    endcase

    unlocked_d = (state_d == ST_OPEN);
    lockout_d  = (state_d == ST_LOCKOUT);
    tries_d    = MAX_T - fails_d;
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_SECURE;
      code_q     <= RESET_CODE;
      fails_q    <= '0;
      timer_q    <= '0;
      unlocked_q <= 1'b0;
      lockout_q  <= 1'b0;
      match_q    <= 1'b0;
      fail_q     <= 1'b0;
      tries_q    <= MAX_T;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      fails_q    <= fails_d;
      timer_q    <= timer_d;
      unlocked_q <= unlocked_d;
      lockout_q  <= lockout_d;
      match_q    <= match_d;
      fail_q     <= fail_d;
      tries_q    <= tries_d;
    end
  end

  assign unlocked   = unlocked_q;
  assign lockout    = lockout_q;
  assign match      = match_q;
  assign fail       = fail_q;
  assign tries_left = tries_q;

endmodule

// File: tb/tb_code_lock_fsm.sv
// Directed bench for code_lock_fsm (CODE_W=3, MAX_TRIES=3, LOCK_CYCLES=8, RESET_CODE=101).
module tb_code_lock_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] code_in;
  logic       code_valid;
  logic       prog;
  logic       lock_req;
  logic       unlocked;
  logic       lockout;
  logic       match;
  logic       fail;
  logic [3:0] tries_left;

  int checks   = 0;
  int failures = 0;

  // Expected output pack: {unlocked, lockout, match, fail, tries_left[3:0]}
  typedef struct {
    logic       cv;
    logic       pg;
    logic       lr;
    logic [2:0] code;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [0:30];

  code_lock_fsm #(
    .CODE_W      (3),
    .MAX_TRIES   (3),
    .LOCK_CYCLES (8),
    .RESET_CODE  (3'b101)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .code_in    (code_in),
    .code_valid (code_valid),
    .prog       (prog),
    .lock_req   (lock_req),
    .unlocked   (unlocked),
    .lockout    (lockout),
    .match      (match),
    .fail       (fail),
    .tries_left (tries_left)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic cv, input logic pg, input logic lr,
                              input logic [2:0] code, input logic [7:0] exp);
    vec_t v;
    v.cv = cv; v.pg = pg; v.lr = lr; v.code = code; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] exp);
    logic [7:0] got;
    got = {unlocked, lockout, match, fail, tries_left};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got{u,l,m,f,tries}=%b required=%b", name, got, exp);
    end
  endtask

  // Present inputs for one clock, then sample 1 time unit after the edge
  task automatic step(input logic cv, input logic pg, input logic lr, input logic [2:0] code);
    code_valid = cv;
    prog       = pg;
    lock_req   = lr;
    code_in    = code;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // u l m f tries
    vecs[0]  = mk(0, 0, 0, 3'b000, 8'b0000_0011); // idle SECURE
    vecs[1]  = mk(1, 0, 0, 3'b101, 8'b1010_0011); // correct code -> OPEN
    vecs[2]  = mk(0, 0, 0, 3'b000, 8'b1000_0011); // pulse gone
    vecs[3]  = mk(0, 0, 1, 3'b000, 8'b0000_0011); // lock_req -> SECURE
    vecs[4]  = mk(1, 0, 0, 3'b011, 8'b0001_0010); // fail 1
    vecs[5]  = mk(1, 0, 0, 3'b110, 8'b0001_0001); // fail 2
    vecs[6]  = mk(1, 0, 0, 3'b000, 8'b0101_0000); // fail 3 -> LOCKOUT (cycle 1)
    vecs[7]  = mk(1, 0, 0, 3'b101, 8'b0100_0000); // ignored (cycle 2)
    vecs[8]  = mk(1, 1, 0, 3'b010, 8'b0100_0000); // ignored (cycle 3)
    vecs[9]  = mk(0, 0, 1, 3'b000, 8'b0100_0000); // ignored (cycle 4)
    vecs[10] = mk(0, 0, 0, 3'b000, 8'b0100_0000); // cycle 5
    vecs[11] = mk(0, 0, 0, 3'b000, 8'b0100_0000); // cycle 6
    vecs[12] = mk(0, 0, 0, 3'b000, 8'b0100_0000); // cycle 7
    vecs[13] = mk(0, 0, 0, 3'b000, 8'b0100_0000); // cycle 8
    vecs[14] = mk(0, 0, 0, 3'b000, 8'b0000_0011); // back to SECURE
    vecs[15] = mk(1, 0, 0, 3'b101, 8'b1010_0011); // open
    vecs[16] = mk(1, 1, 0, 3'b010, 8'b1010_0011); // program 010
    vecs[17] = mk(0, 0, 1, 3'b000, 8'b0000_0011); // lock
    vecs[18] = mk(1, 0, 0, 3'b101, 8'b0001_0010); // old code rejected
    vecs[19] = mk(1, 0, 0, 3'b010, 8'b1010_0011); // new code accepted
    vecs[20] = mk(1, 1, 0, 3'b000, 8'b1001_0011); // program zero rejected
    vecs[21] = mk(1, 0, 0, 3'b011, 8'b1000_0011); // entry in OPEN without prog: no effect
    vecs[22] = mk(1, 1, 1, 3'b110, 8'b0000_0011); // lock_req wins, no pulse
    vecs[23] = mk(1, 0, 0, 3'b010, 8'b1010_0011); // code still 010
    vecs[24] = mk(0, 0, 1, 3'b000, 8'b0000_0011); // lock
    vecs[25] = mk(1, 0, 0, 3'b001, 8'b0001_0010); // fail
    vecs[26] = mk(1, 0, 0, 3'b111, 8'b0001_0001); // fail
    vecs[27] = mk(1, 0, 0, 3'b010, 8'b1010_0011); // match restores tries
    vecs[28] = mk(1, 1, 1, 3'b000, 8'b0000_0011); // lock (prog ignored)
    vecs[29] = mk(1, 0, 0, 3'b000, 8'b0001_0010); // single fail -> 2
    vecs[30] = mk(0, 1, 0, 3'b010, 8'b0000_0010); // prog outside OPEN: no effect

    code_valid = 1'b0;
    prog       = 1'b0;
    lock_req   = 1'b0;
    code_in    = '0;
    reset      = 1'b1;
    #1;
    check("reset_state", 8'b0000_0011);
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_idle", 8'b0000_0011);

    for (int i = 0; i < 31; i++) begin
      step(vecs[i].cv, vecs[i].pg, vecs[i].lr, vecs[i].code);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Reset in cycle 4 of lockout; stored code is 010 and must revert to 101
    step(1, 0, 0, 3'b011);
    check("pre_lock_fail2", 8'b0001_0001);
    step(1, 0, 0, 3'b011);
    check("lockout_enter", 8'b0101_0000);
    step(0, 0, 0, 3'b000);
    step(0, 0, 0, 3'b000);
    step(0, 0, 0, 3'b000);
    check("lockout_cycle4", 8'b0100_0000);
    reset = 1'b1;
    #1;
    check("async_reset_lockout", 8'b0000_0011);
    #2;
    reset = 1'b0;
    step(0, 0, 0, 3'b000);
    check("after_reset_no_pulse", 8'b0000_0011);
    step(1, 0, 0, 3'b010);
    check("code010_reverted", 8'b0001_0010);
    step(1, 0, 0, 3'b101);
    check("code101_restored", 8'b1010_0011);

    // Reset while OPEN with a code valid on the same cycle as release
    reset = 1'b1;
    #1;
    check("async_reset_open", 8'b0000_0011);
    #2;
    reset = 1'b0;
    step(0, 0, 0, 3'b000);
    check("open_aborted", 8'b0000_0011);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety bound so the run always terminates
  initial begin
    #20000;
    $display("FAIL timeout got=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
